// File: rtl/alu_unit.sv
// alu_unit: 6-bit signed ALU with registered result, zero and signed-overflow flags.
// One operation per cycle, one cycle of latency; async reset clears to a zero result.
module alu_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic [2:0] fxn,
    output logic [5:0] alu_ans,
    output logic       zero,
    output logic       ovf
);
    logic [6:0]         sum, dif;
    logic signed [11:0] prod;
    logic [5:0]         shl;
    logic               slt, mul_ovf;
    logic [5:0]         alu_ans_d, alu_ans_q;
    logic               ovf_d, ovf_q, zero_q;

    // Sign-extend to 7 bits so bits 6 and 5 disagree exactly on overflow.
    assign sum     = {a[5], a} + {b[5], b};
    assign dif     = {a[5], a} - {b[5], b};
    assign prod    = $signed(a) * $signed(b);
    assign mul_ovf = !((&prod[11:5]) || !(|prod[11:5]));
    assign shl     = (b[2:0] > 3'd5) ? 6'd0 : a << b[2:0];
    assign slt     = $signed(a) < $signed(b);

    always_comb begin
        alu_ans_d = 6'd0;
        ovf_d     = 1'b0;
        case (fxn)
            3'b000: begin alu_ans_d = sum[5:0];  ovf_d = sum[6] ^ sum[5]; end
            3'b001: begin alu_ans_d = dif[5:0];  ovf_d = dif[6] ^ dif[5]; end
            3'b010: alu_ans_d = a & b;
            3'b011: alu_ans_d = a | b;
            3'b100: alu_ans_d = a ^ b;
            3'b101: begin alu_ans_d = prod[5:0]; ovf_d = mul_ovf; end
            3'b110: alu_ans_d = shl;
            default: alu_ans_d = {5'd0, slt};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_ans_q <= 6'd0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            alu_ans_q <= alu_ans_d;
            zero_q    <= (alu_ans_d == 6'd0);
            ovf_q     <= ovf_d;
        end
    end

    assign alu_ans = alu_ans_q;
    assign zero    = zero_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against an integer reference model.
module tb_alu_unit;
    logic       clk, rst;
    logic [5:0] a, b;
    logic [2:0] fxn;
    logic [5:0] alu_ans;
    logic       zero, ovf;
    int         tests = 0;
    int         fails = 0;

    alu_unit dut (.clk(clk), .rst(rst), .a(a), .b(b), .fxn(fxn),
                  .alu_ans(alu_ans), .zero(zero), .ovf(ovf));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference model: plain signed integer arithmetic, then keep the low 6 bits.
    function automatic void model(input logic [5:0] ta, input logic [5:0] tb,
                                  input logic [2:0] tf, output logic [5:0] r, output logic o);
        int sa, sb, v;
        sa = int'(ta); if (sa > 31) sa -= 64;
        sb = int'(tb); if (sb > 31) sb -= 64;
        o = 1'b0;
        case (tf)
            3'd0: begin v = sa + sb; o = (v < -32 || v > 31); end
            3'd1: begin v = sa - sb; o = (v < -32 || v > 31); end
            3'd2: v = int'(ta & tb);
            3'd3: v = int'(ta | tb);
            3'd4: v = int'(ta ^ tb);
            3'd5: begin v = sa * sb; o = (v < -32 || v > 31); end
            3'd6: v = (int'(tb[2:0]) >= 6) ? 0 : (int'(ta) << tb[2:0]);
            default: v = (sa < sb) ? 1 : 0;
        endcase
        r = v[5:0];
    endfunction

    // Apply inputs at negedge, scramble them after the edge, then check the registered result.
    task automatic step(input string tag, input logic [5:0] ta, input logic [5:0] tb,
                        input logic [2:0] tf, input logic [5:0] ea, input logic eo);
        @(negedge clk);
        a = ta; b = tb; fxn = tf;
        @(posedge clk);
        #1;
        a = ~ta; b = 6'($urandom); fxn = tf + 3'd1;
        #1;
        chk({tag, "_ans"}, alu_ans, ea);
        chk({tag, "_zero"}, {5'd0, zero}, {5'd0, ea == 6'd0});
        chk({tag, "_ovf"}, {5'd0, ovf}, {5'd0, eo});
    endtask

    task automatic rstep(input string tag, input logic [5:0] ta, input logic [5:0] tb,
                         input logic [2:0] tf);
        logic [5:0] ea;
        logic       eo;
        model(ta, tb, tf, ea, eo);
        step(tag, ta, tb, tf, ea, eo);
    endtask

    initial begin
        logic [5:0] ra, rb;
        logic [5:0] corner [4];
        corner[0] = 6'b100000; corner[1] = 6'b011111; corner[2] = 6'b000000; corner[3] = 6'b111111;
        rst = 1; a = 0; b = 0; fxn = 0;
        repeat (2) @(negedge clk);
        chk("reset_ans", alu_ans, 6'd0);
        chk("reset_zero", {5'd0, zero}, 6'd1);
        chk("reset_ovf", {5'd0, ovf}, 6'd0);
        rst = 0;
        step("add_0_1",   6'b000000, 6'b000001, 3'b000, 6'b000001, 1'b0);
        step("sub_2_5",   6'b000010, 6'b000101, 3'b001, 6'b111101, 1'b0);
        step("or",        6'b101011, 6'b110011, 3'b011, 6'b111011, 1'b0);
        step("and",       6'b001000, 6'b001010, 3'b010, 6'b001000, 1'b0);
        step("xor",       6'b100000, 6'b110001, 3'b100, 6'b010001, 1'b0);
        step("add_ovf",   6'b100000, 6'b110001, 3'b000, 6'b010001, 1'b1);
        step("mul_ovf",   6'b010111, 6'b010001, 3'b101, 6'b000111, 1'b1);
        step("shl_2",     6'b111010, 6'b001010, 3'b110, 6'b101000, 1'b0);
        step("sub_min",   6'b100000, 6'b000001, 3'b001, 6'b011111, 1'b1);
        step("mul_min",   6'b100000, 6'b111111, 3'b101, 6'b100000, 1'b1);
        step("slt_eq",    6'b100101, 6'b100101, 3'b111, 6'b000000, 1'b0);
        step("shl_6",     6'b111111, 6'b000110, 3'b110, 6'b000000, 1'b0);
        step("shl_7",     6'b111111, 6'b001111, 3'b110, 6'b000000, 1'b0);
        step("mul_small", 6'b111101, 6'b000101, 3'b101, 6'b110001, 1'b0);
        step("slt_lt",    6'b001010, 6'b001100, 3'b111, 6'b000001, 1'b0);
        // Asynchronous reset mid-cycle, well before the next rising edge.
        #1 rst = 1;
        #1;
        chk("async_rst_ans", alu_ans, 6'd0);
        chk("async_rst_zero", {5'd0, zero}, 6'd1);
        chk("async_rst_ovf", {5'd0, ovf}, 6'd0);
        @(negedge clk);
        a = 6'd3; b = 6'd4; fxn = 3'b000;
        @(posedge clk);
        #1;
        chk("held_rst_ans", alu_ans, 6'd0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        chk("post_rst_ans", alu_ans, 6'd7);
        chk("post_rst_zero", {5'd0, zero}, 6'd0);
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 6'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 6'($urandom);
            rstep("rand", ra, rb, 3'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port a, input, 6 bits: operand A, two's-complement signed.
REQ-005 Port b, input, 6 bits: operand B, two's-complement signed.
REQ-006 Port fxn, input, 3 bits, unsigned: operation select.
REQ-007 Port alu_ans, output, 6 bits: registered result, two's-complement.
REQ-008 Port zero, output, 1 bit: registered flag, high when alu_ans is 000000.
REQ-009 Port ovf, output, 1 bit: registered signed-overflow flag.
REQ-010 The block SHALL have no parameters; all widths SHALL be fixed at 6-bit data and 3-bit select.

Function
REQ-011 On each rising clk edge with rst low, the block SHALL capture f(a,b,fxn) into alu_ans, zero and ovf, giving 1-cycle latency with no handshake; a new operation is accepted every cycle.
REQ-012 fxn=000 ADD SHALL give alu_ans = (a+b) mod 64, with ovf=1 when the signed sum is outside -32..31.
REQ-013 fxn=001 SUB SHALL give alu_ans = (a-b) mod 64, with ovf=1 when the signed difference is outside -32..31.
REQ-014 fxn=010 SHALL give bitwise a AND b, with ovf=0.
REQ-015 fxn=011 SHALL give bitwise a OR b, with ovf=0.
REQ-016 fxn=100 SHALL give bitwise a XOR b, with ovf=0.
REQ-017 fxn=101 MUL SHALL compute the signed 12-bit product a*b; alu_ans SHALL be the low 6 bits; ovf=1 when the product is outside -32..31.
REQ-018 fxn=110 SHL SHALL give a logically shifted left by the unsigned amount b[2:0], zero-filled; shifts of 6 or 7 SHALL give 000000; ovf=0.
REQ-019 fxn=111 SLT SHALL give alu_ans = 000001 when a < b (signed), else 000000; ovf=0.
REQ-020 zero SHALL reflect the registered alu_ans value for every fxn.
REQ-021 Only the low 6 bits SHALL be kept; wrap-around SHALL be silent except for ovf.
REQ-022 Edge cases SHALL behave as follows: a=-32 minus b=1 gives 011111 with ovf=1; -32*-1 gives 100000 with ovf=1; SLT with a=b gives 0.
REQ-023 The outputs SHALL depend only on the previous-edge inputs; input changes between edges SHALL have no effect on the outputs.

Reset
REQ-024 While rst is high, the block SHALL immediately, without waiting for clk, force alu_ans=000000, zero=1 and ovf=0.
REQ-025 A reset asserted mid-stream SHALL discard any pending result; the first edge after rst falls SHALL register f of the inputs present at that edge.
REQ-026 The block SHALL hold no state other than the three output registers.

Verification
REQ-027 The bench SHALL cover the following scenarios, each checked one cycle after the inputs are applied:
- a=000000, b=000001, fxn=000 -> alu_ans=000001, zero=0, ovf=0.
- a=000010, b=000101, fxn=001 -> alu_ans=111101 (-3), ovf=0.
- a=101011 (-21), b=110011 (-13), fxn=011 -> alu_ans=111011; with fxn=010, a=001000, b=001010 -> alu_ans=001000.
- a=100000 (-32), b=110001 (-15), fxn=100 -> alu_ans=010001; with fxn=000 on the same operands -> alu_ans=010001, ovf=1.
- a=010111 (23), b=010001 (17), fxn=101 -> alu_ans=000111, ovf=1; a=111010 (-6), b=001010, fxn=110 -> alu_ans=101000.
- a=001010, b=001100, fxn=111 -> alu_ans=000001; then assert rst asynchronously -> alu_ans=000000, zero=1, ovf=0 before the next edge.
